// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining a FIFO, 16x oversampled baud ticks.
// Optional even-parity bit enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICKS   = 16,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_empty,
  input  logic [DATA_BITS-1:0]  i_r_data,
  output logic                  o_rd,
  input  logic [DVSR_WIDTH-1:0] i_dvsr,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  localparam int S_W = $clog2(16 * SB_TICKS);
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic [2:0]            state, state_next;
  logic [DVSR_WIDTH-1:0] t_cnt;
  logic                  tick;
  logic [S_W-1:0]        s_cnt, s_next;
  logic [N_W-1:0]        n_cnt, n_next;
  logic [DATA_BITS-1:0]  b_reg, b_next;
  logic                  tx_reg, tx_next;
  logic                  pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_reg, par_next;
`endif

  // Magnitude compare so a divisor lowered mid-count still wraps on the next cycle
  assign tick = (t_cnt >= i_dvsr);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      t_cnt <= '0;
    end else if (pop || tick) begin
      t_cnt <= '0;
    end else begin
      t_cnt <= t_cnt + DVSR_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      b_reg  <= '0;
      tx_reg <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      s_cnt  <= s_next;
      n_cnt  <= n_next;
      b_reg  <= b_next;
      tx_reg <= tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s_cnt;
    n_next     = n_cnt;
    b_next     = b_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!i_empty) begin
          pop        = 1'b1;
          state_next = ST_START;
          s_next     = '0;
          n_next     = '0;
          b_next     = i_r_data;
          tx_next    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
          par_next   = ^i_r_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_cnt == S_W'(15)) begin
            state_next = ST_DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_cnt + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_cnt == S_W'(15)) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_cnt == N_W'(DATA_BITS - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_next = ST_PARITY;
              tx_next    = par_reg;
`else
              state_next = ST_STOP;
              tx_next    = 1'b1;
`endif
            end else begin
              n_next  = n_cnt + N_W'(1);
              tx_next = b_next[0];
            end
          end else begin
            s_next = s_cnt + S_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (s_cnt == S_W'(15)) begin
            state_next = ST_STOP;
            s_next     = '0;
            tx_next    = 1'b1;
          end else begin
            s_next = s_cnt + S_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (s_cnt == S_W'(SB_TICKS - 1)) begin
            s_next = '0;
            // Chain straight into the next start bit when another word is waiting
            if (!i_empty) begin
              pop        = 1'b1;
              state_next = ST_START;
              n_next     = '0;
              b_next     = i_r_data;
              tx_next    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
              par_next   = ^i_r_data;
`endif
            end else begin
              state_next = ST_IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            s_next = s_cnt + S_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Gating by reset keeps the pop strobe low while the block is held in reset
  assign o_rd   = pop & i_reset_n;
  assign o_tx   = tx_reg;
  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] dvsr = 11'd3;
  logic        empty;
  logic [7:0]  r_data;
  logic        rd, tx, busy;

  logic [7:0]  fifo_mem [0:7];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int tests = 0, fails = 0;
  int cyc = 0, rd_total = 0, busy_total = 0, last_rd = 0, prev_rd = 0;
  int rd0, b0, errs;

  always #5 clk = ~clk;

  fifo_uart_tx dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_empty   (empty),
    .i_r_data  (r_data),
    .o_rd      (rd),
    .i_dvsr    (dvsr),
    .o_tx      (tx),
    .o_busy    (busy)
  );

  assign empty  = (wr_ptr == rd_ptr);
  assign r_data = fifo_mem[rd_ptr[2:0]];

  always @(posedge clk) if (rd) rd_ptr <= rd_ptr + 1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd) begin
      rd_total <= rd_total + 1;
      prev_rd  <= last_rd;
      last_rd  <= cyc;
    end
    if (busy) busy_total <= busy_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr[2:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic exp_tx(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[3'(slot - 1)];
`ifdef FIFO_UART_TX_PARITY_EN
    if (slot == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Samples a whole frame; assumes the pop edge is the next rising edge
  task automatic check_frame(input logic [7:0] d, input int bc, input string tag);
    int e;
    e = 0;
    for (int k = 1; k <= NSLOT * bc; k++) begin
      sample_point();
      if (tx !== exp_tx(d, (k - 1) / bc)) e++;
    end
    check(tag, e, 0);
  endtask

  initial begin
    repeat (3) sample_point();
    check("reset_tx", 32'(tx), 1);
    check("reset_rd", 32'(rd), 0);
    check("reset_busy", 32'(busy), 0);

    drive_point();
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 2000; i++) begin
      sample_point();
      if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) errs++;
    end
    check("idle_2000", errs, 0);

    // single word 0x55
    drive_point();
    rd0 = rd_total; b0 = busy_total;
    push(8'h55);
    sample_point();
    check("pop_55", 32'(rd), 1);
    check_frame(8'h55, 64, "frame_55");
    check("rd_count_55", rd_total - rd0, 1);
    check("busy_55", busy_total - b0, NSLOT * 64);
    sample_point();
    check("post_tx_55", 32'(tx), 1);
    check("post_busy_55", 32'(busy), 0);

    // back-to-back 0xA5, 0x3C
    drive_point();
    rd0 = rd_total; b0 = busy_total;
    push(8'hA5);
    push(8'h3C);
    sample_point();
    check("pop_a5", 32'(rd), 1);
    check_frame(8'hA5, 64, "frame_a5");
    check_frame(8'h3C, 64, "frame_3c");
    check("rd_count_pair", rd_total - rd0, 2);
    check("rd_gap_pair", last_rd - prev_rd, NSLOT * 64);
    check("busy_pair", busy_total - b0, 2 * NSLOT * 64);
    sample_point();
    check("post_tx_pair", 32'(tx), 1);

    // 0x07: three ones, parity bit 1 when enabled
    drive_point();
    b0 = busy_total;
    push(8'h07);
    sample_point();
    check("pop_07", 32'(rd), 1);
    check_frame(8'h07, 64, "frame_07");
    check("busy_07", busy_total - b0, NSLOT * 64);
    sample_point();
    check("post_tx_07", 32'(tx), 1);

    // reset 200 clocks into a 0xFF frame
    drive_point();
    push(8'hFF);
    repeat (200) sample_point();
    check("busy_before_abort", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_rd", 32'(rd), 0);
    repeat (5) sample_point();
    drive_point();
    rd0 = rd_total;
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      sample_point();
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("after_abort_idle", errs, 0);
    check("after_abort_no_rd", rd_total - rd0, 0);

    // dvsr=0, word waiting across reset release: pop on first edge
    drive_point();
    rst_n = 1'b0;
    dvsr = 11'd0;
    push(8'h81);
    sample_point();
    check("rd_in_reset", 32'(rd), 0);
    drive_point();
    rd0 = rd_total; b0 = busy_total;
    rst_n = 1'b1;
    sample_point();
    check("pop_first_edge", 32'(rd), 1);
    check_frame(8'h81, 16, "frame_81_dvsr0");
    check("busy_81", busy_total - b0, NSLOT * 16);
    check("rd_count_81", rd_total - rd0, 1);
    sample_point();
    check("post_tx_81", 32'(tx), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame (5..9).
REQ-002 SHALL have parameter SB_TICKS, default 16: stop-bit length in oversample ticks (16/24/32 = 1/1.5/2 stop bits).
REQ-003 SHALL have parameter DVSR_WIDTH, default 11: width of i_dvsr.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_empty  input  1  empty flag of the feeding FIFO.
REQ-007 SHALL have port i_r_data  input  DATA_BITS  FIFO head word, valid whenever i_empty=0.
REQ-008 SHALL have port o_rd  output  1  FIFO pop strobe, one cycle per word.
REQ-009 SHALL have port i_dvsr  input  DVSR_WIDTH  baud divisor; tick period = i_dvsr+1 clocks (16x oversample).
REQ-010 SHALL have port o_tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-027).
REQ-013 Tick generator SHALL count 0..i_dvsr, pulse one cycle at i_dvsr, and clear on each pop; i_dvsr=0 gives a tick every clock.
REQ-014 IDLE with i_empty=0 SHALL assert o_rd for exactly one cycle, latch i_r_data into the shift register, and enter START.
REQ-015 o_rd SHALL never assert while i_empty=1 or outside the pop cycle of REQ-014/REQ-019.
REQ-016 o_tx SHALL go low on the clock edge after the pop cycle (latency 1).
REQ-017 START SHALL hold o_tx=0 for 16 ticks, then DATA.
REQ-018 DATA SHALL send DATA_BITS bits LSB first, 16 ticks each, shifting right after each bit.
REQ-019 STOP SHALL hold o_tx=1 for SB_TICKS ticks; at its final tick, if i_empty=0, SHALL pop and go directly to START (no idle cycle), else go to IDLE.
REQ-020 Frame length SHALL be (16*(1+DATA_BITS[+1 parity])+SB_TICKS)*(i_dvsr+1) clocks with i_dvsr constant.
REQ-021 i_dvsr changes mid-frame SHALL take effect at the next tick-counter wrap; no glitch on o_tx.
REQ-022 Tick and bit counters SHALL be sized to hold 16*SB_TICKS-1 and DATA_BITS-1 without overflow.
REQ-023 i_r_data changes after the pop cycle SHALL not affect the frame in flight.

Reset
REQ-024 On i_reset_n=0, asynchronously: state=IDLE, o_tx=1, o_rd=0, o_busy=0, counters and shift register cleared.
REQ-025 Reset mid-frame SHALL abort the frame, drive o_tx=1 immediately, and not re-pop the aborted word.
REQ-026 After reset release with i_empty=0, the first pop SHALL occur on the first clock edge.

Configuration
REQ-027 With macro FIFO_UART_TX_PARITY_EN defined, state PARITY SHALL follow DATA and send the even-parity bit (XOR of data bits) for 16 ticks before STOP.
REQ-028 Without FIFO_UART_TX_PARITY_EN, PARITY and its logic SHALL not exist and DATA SHALL go directly to STOP.

Verification (DATA_BITS=8, SB_TICKS=16, i_dvsr=3: bit = 64 clocks)
REQ-029 i_empty=1 for 2000 clocks -> o_tx=1, o_rd=0, o_busy=0 throughout.
REQ-030 One word 0x55 -> single o_rd pulse; o_tx: 64 low, then 1,0,1,0,1,0,1,0 at 64 clocks each, then 64 high; o_busy high 640 clocks.
REQ-031 Words 0xA5, 0x3C queued -> two o_rd pulses 640 clocks apart; second start bit begins the cycle after the first stop bit ends; total 1280 busy clocks.
REQ-032 Reset asserted 200 clocks into 0xFF frame -> o_tx=1 immediately; after release with FIFO empty, no o_rd and o_tx stays 1.
REQ-033 FIFO_UART_TX_PARITY_EN defined, word 0x07 -> parity bit 1 after bit 7; frame 704 clocks; undefined -> frame 640 clocks.
REQ-034 i_dvsr=0, word 0x81 -> each bit 16 clocks; frame 160 clocks; LSB 1 first, MSB 1 last.
